// File: rtl/sha256_pkg.sv
// SHA-256 constants and round helper functions shared by the compression
// core and the SHA-256d header sequencer.
package sha256_pkg;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA256_PAD_WORD = 32'h80000000;
  localparam logic [63:0] SHA256_LEN_HDR  = 64'd640;
  localparam logic [63:0] SHA256_LEN_DGST = 64'd256;

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress.sv
// One-round-per-cycle SHA-256 compression core. A start pulse loads the
// chunk and chaining state; 64 rounds follow, then one cycle for the final
// feed-forward add. finish pulses for one cycle, 66 cycles after start, with
// state_out already valid and held until the next pass completes.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] chunk,
  input  logic [255:0] state_in,
  output logic         finish,
  output logic [255:0] state_out
);

  logic         active_q;
  logic [6:0]   rnd_left;
  logic [5:0]   k_idx;
  logic [31:0]  w_q [16];
  logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [255:0] base_q;
  logic [31:0]  t1, t2, w_new;

  // round index counts up while the round timer counts down from 64
  assign k_idx = 6'd0 - rnd_left[5:0];

  // round datapath and message schedule for the current round
  always_comb begin
    t1    = h_q + bsig1(e_q) + ((e_q & f_q) ^ (~e_q & g_q)) + SHA256_K[k_idx] + w_q[0];
    t2    = bsig0(a_q) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
    w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
  end

  // load on start, run rounds until the timer expires, then feed forward
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= 1'b0;
      rnd_left  <= 7'd0;
      finish    <= 1'b0;
      state_out <= '0;
    end else begin
      finish <= 1'b0;
      if (start && !active_q) begin
        active_q <= 1'b1;
        rnd_left <= 7'd64;
        base_q   <= state_in;
        for (int i = 0; i < 16; i++) w_q[i] <= chunk[511 - 32*i -: 32];
        {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= state_in;
      end else if (active_q && rnd_left != 7'd0) begin
        rnd_left <= rnd_left - 7'd1;
        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
        w_q[15] <= w_new;
        h_q <= g_q;
        g_q <= f_q;
        f_q <= e_q;
        e_q <= d_q + t1;
        d_q <= c_q;
        c_q <= b_q;
        b_q <= a_q;
        a_q <= t1 + t2;
      end else if (active_q) begin
        active_q  <= 1'b0;
        finish    <= 1'b1;
        state_out <= {base_q[255:224] + a_q, base_q[223:192] + b_q,
                      base_q[191:160] + c_q, base_q[159:128] + d_q,
                      base_q[127:96]  + e_q, base_q[95:64]   + f_q,
                      base_q[63:32]   + g_q, base_q[31:0]    + h_q};
      end
    end
  end

endmodule

// File: rtl/sha256d_header_ctrl.sv
// SHA-256d sequencer for an 80-byte block header, built around one shared
// compression core: header chunk 0, padded header chunk 1, then the padded
// first digest. Returns the raw double hash (H0 in the top word).
// Optional midstate cache: define SHA256D_MIDSTATE_CACHE_EN to skip chunk 0
// when the first 64 header bytes match the last computed chunk 0.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | ready for a header
// C0_GO   | start pass over header bytes 0..63 from the IV
// C0_WAIT | wait for chunk 0 result (midstate)
// C1_GO   | start pass over bytes 64..79 + padding from midstate
// C1_WAIT | wait for first digest
// C2_GO   | start pass over padded first digest from the IV
// C2_WAIT | wait for final digest
// DONE    | digest offered until accepted
module sha256d_header_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [639:0] header,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, C0_GO, C0_WAIT, C1_GO, C1_WAIT, C2_GO, C2_WAIT, DONE
  } state_t;

  state_t       state;
  logic [639:0] header_q;
  logic [255:0] midstate;
  logic [255:0] digest_q;
  logic         core_start;
  logic         core_finish;
  logic [511:0] core_chunk;
  logic [255:0] core_state_in;
  logic [255:0] core_state_out;

`ifdef SHA256D_MIDSTATE_CACHE_EN
  logic [511:0] cache_tag;
  logic [255:0] cache_mid;
  logic         cache_valid;
  logic         cache_hit;

  assign cache_hit = cache_valid && (cache_tag == header[639:128]);

  // remember the latest chunk-0 result, keyed by the bytes that produced it
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
    end else if (state == C0_WAIT && core_finish) begin
      cache_valid <= 1'b1;
      cache_tag   <= header_q[639:128];
      cache_mid   <= core_state_out;
    end
  end
`endif

  assign digest = digest_q;

  // core operands depend only on the pass, so they hold across GO and WAIT
  always_comb begin
    core_chunk    = '0;
    core_state_in = SHA256_IV;
    case (state)
      C0_GO, C0_WAIT: core_chunk = header_q[639:128];
      C1_GO, C1_WAIT: begin
        core_chunk    = {header_q[127:0], SHA256_PAD_WORD, 288'b0, SHA256_LEN_HDR};
        core_state_in = midstate;
      end
      C2_GO, C2_WAIT: core_chunk = {digest_q, SHA256_PAD_WORD, 160'b0, SHA256_LEN_DGST};
      default: ;
    endcase
  end

  // sequencer with registered handshake, status and core start
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      header_q   <= '0;
      midstate   <= '0;
      digest_q   <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          header_q   <= header;
          in_ready   <= 1'b0;
          busy       <= 1'b1;
          core_start <= 1'b1;
`ifdef SHA256D_MIDSTATE_CACHE_EN
          if (cache_hit) begin
            midstate <= cache_mid;
            state    <= C1_GO;
          end else begin
            state <= C0_GO;
          end
`else
          state <= C0_GO;
`endif
        end
        C0_GO: state <= C0_WAIT;
        C0_WAIT: if (core_finish) begin
          midstate   <= core_state_out;
          core_start <= 1'b1;
          state      <= C1_GO;
        end
        C1_GO: state <= C1_WAIT;
        C1_WAIT: if (core_finish) begin
          digest_q   <= core_state_out;
          core_start <= 1'b1;
          state      <= C2_GO;
        end
        C2_GO: state <= C2_WAIT;
        C2_WAIT: if (core_finish) begin
          digest_q  <= core_state_out;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sha256_compress u_compress (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .chunk     (core_chunk),
    .state_in  (core_state_in),
    .finish    (core_finish),
    .state_out (core_state_out)
  );

endmodule

// File: tb/tb_sha256d_header_ctrl.sv
// Self-checking bench for sha256d_header_ctrl against a byte-level software
// SHA-256d model. Expected hit latency follows SHA256D_MIDSTATE_CACHE_EN.
module tb_sha256d_header_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [639:0] header;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  localparam logic [639:0] GENESIS = {
    32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
  };
  localparam logic [255:0] GENESIS_DIGEST =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

`ifdef SHA256D_MIDSTATE_CACHE_EN
  localparam int HIT_LAT = 135;
`else
  localparam int HIT_LAT = 202;
`endif
  localparam int MISS_LAT = 202;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256d_header_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .header    (header),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest    (digest),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // plain software SHA-256 of the first len bytes of m
  function automatic logic [255:0] sha_msg(input logic [7:0] m [80], input int len);
    logic [7:0]  blk [128];
    logic [31:0] hs [8];
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [63:0] bl;
    int nblk;
    nblk = (len + 72) / 64;
    for (int i = 0; i < 128; i++) begin
      blk[i] = 8'h00;
      if (i < len) blk[i] = m[i];
    end
    blk[len] = 8'h80;
    bl = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) blk[nblk*64 - 1 - i] = bl[8*i +: 8];
    hs = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int b = 0; b < nblk; b++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {blk[b*64+4*t], blk[b*64+4*t+1], blk[b*64+4*t+2], blk[b*64+4*t+3]};
      for (int t = 16; t < 64; t++) begin
        s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      v = hs;
      for (int t = 0; t < 64; t++) begin
        t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
             + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
        t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
             + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        for (int k = 7; k > 0; k--) v[k] = v[k-1];
        v[4] = v[4] + t1;
        v[0] = t1 + t2;
      end
      for (int k = 0; k < 8; k++) hs[k] = hs[k] + v[k];
    end
    return {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
  endfunction

  function automatic logic [255:0] dsha(input logic [639:0] hd);
    logic [7:0]   m [80];
    logic [255:0] d1;
    for (int i = 0; i < 80; i++) m[i] = hd[639 - 8*i -: 8];
    d1 = sha_msg(m, 80);
    for (int i = 0; i < 80; i++) m[i] = (i < 32) ? d1[255 - 8*i -: 8] : 8'h00;
    return sha_msg(m, 32);
  endfunction

  function automatic logic [639:0] rand_header();
    logic [639:0] h;
    for (int k = 0; k < 20; k++) h[32*k +: 32] = $urandom;
    return h;
  endfunction

  // offer a header and return the cycle in which it was accepted
  task automatic submit(input logic [639:0] h, output int t_acc);
    bit got = 0;
    t_acc = -1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    header   = h;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        t_acc = cyc;
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: in_ready never high within 500 cycles, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // wait for out_valid; returns at the negedge of its first cycle
  task automatic wait_out(input int t_acc, output int lat);
    bit got = 0;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - t_acc;
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL out_timeout: out_valid never high within 400 cycles, required 1");
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (digest !== 256'h0) begin errors++; $display("FAIL reset_digest: got %h required 0", digest); end
  endtask

  task automatic test_genesis();
    int t, lat;
    logic [255:0] exp_d;
    exp_d = dsha(GENESIS);
    submit(GENESIS, t);
    wait_out(t, lat);
    checks++; if (lat != MISS_LAT) begin errors++; $display("FAIL genesis_latency: got %0d required %0d", lat, MISS_LAT); end
    checks++; if (digest !== GENESIS_DIGEST) begin errors++; $display("FAIL genesis_digest: got %h required %h", digest, GENESIS_DIGEST); end
    checks++; if (digest !== exp_d) begin errors++; $display("FAIL genesis_model: got %h required %h", digest, exp_d); end
    drain();
  endtask

  task automatic test_nonce_change();
    int t, lat;
    logic [639:0] h;
    logic [255:0] exp_d;
    h = {GENESIS[639:32], 32'h1dac2b7d};
    exp_d = dsha(h);
    submit(h, t);
    wait_out(t, lat);
    checks++; if (lat != HIT_LAT) begin errors++; $display("FAIL nonce_latency: got %0d required %0d", lat, HIT_LAT); end
    checks++; if (digest !== exp_d) begin errors++; $display("FAIL nonce_digest: got %h required %h", digest, exp_d); end
    drain();
  endtask

  task automatic test_backpressure();
    int t, lat;
    logic [639:0] h;
    logic [255:0] exp_d;
    h = rand_header();
    exp_d = dsha(h);
    submit(h, t);
    wait_out(t, lat);
    checks++; if (digest !== exp_d) begin errors++; $display("FAIL bp_digest: got %h required %h", digest, exp_d); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (digest !== exp_d || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b ready=%b busy=%b digest=%h required 1/0/1 %h",
                 i, out_valid, in_ready, busy, digest, exp_d);
      end
    end
    drain();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: ready=%b busy=%b valid=%b required 1/0/0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_ignore_busy();
    int t, lat;
    logic [639:0] ha, hb;
    logic [255:0] exp_d;
    ha = rand_header();
    hb = rand_header();
    exp_d = dsha(ha);
    submit(ha, t);
    repeat (49) @(posedge clk);
    #1;
    in_valid = 1'b1;
    header   = hb;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(t, lat);
    checks++; if (lat != MISS_LAT) begin errors++; $display("FAIL ignore_latency: got %0d required %0d", lat, MISS_LAT); end
    checks++; if (digest !== exp_d) begin errors++; $display("FAIL ignore_digest: got %h required %h", digest, exp_d); end
    drain();
  endtask

  task automatic test_reset_mid();
    int t, lat;
    bit saw_out = 0;
    bit saw_busy = 0;
    submit(GENESIS, t);
    repeat (99) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: valid=%b ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    end
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_out = 1;
      if (busy !== 1'b0) saw_busy = 1;
    end
    checks++;
    if (saw_out || saw_busy) begin
      errors++;
      $display("FAIL midreset_quiet: out_valid_seen=%b busy_seen=%b required 0/0", saw_out, saw_busy);
    end
    submit(GENESIS, t);
    wait_out(t, lat);
    checks++; if (lat != MISS_LAT) begin errors++; $display("FAIL midreset_latency: got %0d required %0d", lat, MISS_LAT); end
    checks++; if (digest !== GENESIS_DIGEST) begin errors++; $display("FAIL midreset_digest: got %h required %h", digest, GENESIS_DIGEST); end
    drain();
  endtask

  task automatic test_back_to_back();
    int t, t_prev, lat;
    logic [639:0] h;
    logic [255:0] exp_d;
    t_prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      h = rand_header();
      exp_d = dsha(h);
      submit(h, t);
      if (i > 0) begin
        checks++;
        if (t - t_prev != 203) begin
          errors++;
          $display("FAIL b2b_spacing %0d: got %0d required 203", i, t - t_prev);
        end
      end
      t_prev = t;
      wait_out(t, lat);
      checks++;
      if (digest !== exp_d) begin
        errors++;
        $display("FAIL b2b_digest %0d: got %h required %h", i, digest, exp_d);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    header    = '0;
    test_reset();
    test_genesis();
    test_nonce_change();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256d_header_ctrl.md
# sha256d_header_ctrl

Sequencer that computes Bitcoin SHA-256d over an 80-byte block header with one shared `sha256_compress` core. It accepts a header through a valid/ready handshake and issues three compression passes: header chunk 0, header chunk 1 with padding, and the padded first digest. It returns the raw 256-bit double hash through a second valid/ready handshake. It sits between the job/nonce source and the target comparator.

## Interface
Parameters: none.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  header offered
- in_ready  out  1  high only in IDLE
- header  in  640  header bytes; byte 0 at [639:632]
- out_valid  out  1  digest available
- out_ready  in  1  consumer accepts digest
- digest  out  256  raw SHA-256d; H0 at [255:224]; no byte reversal
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, C0_GO, C0_WAIT, C1_GO, C1_WAIT, C2_GO, C2_WAIT, DONE.
- IDLE: when in_valid is high, latch header and go to C0_GO. With the cache enabled and a hit, go to C1_GO instead.
- In each *_GO state, assert core start for exactly one cycle, then move to the matching *_WAIT.
- In each *_WAIT state, hold chunk and state_in constant until core finish = 1, then:
  - C0_WAIT: capture state_out into midstate and go to C1_GO.
  - C1_WAIT: capture into digest_q and go to C2_GO.
  - C2_WAIT: capture into digest_q and go to DONE.
- C0: chunk = header[639:128], state_in = IV.
- C1: chunk = {header[127:0], 32'h80000000, 288'b0, 64'd640}, state_in = midstate.
- C2: chunk = {digest_q, 32'h80000000, 160'b0, 64'd256}, state_in = IV.
- The core latches chunk/state_in in the cycle after start, so driving them from registers held across *_GO and *_WAIT is sufficient.
- DONE: out_valid = 1 and digest = digest_q. When out_ready is high, go to IDLE. in_ready rises the following cycle; there is no same-cycle accept.
- All arithmetic lives in the core; this block only muxes and registers.
- Reset values: in_ready 1, out_valid 0, busy 0, digest 0, FSM IDLE. Midstate, digest_q and the cache valid bit are cleared.
- Reset mid-operation aborts immediately. The core shares reset and returns to its idle state. No partial digest is emitted.
- in_valid while busy is ignored; the header is not latched.

## Timing
- Handshake accepted in cycle T (cache miss):
  - C0 start at T+1, finish at T+67.
  - C1 start at T+68, finish at T+134.
  - C2 start at T+135, finish at T+201.
  - out_valid = 1 at T+202.
- Cache hit: C1 start at T+1, out_valid = 1 at T+135.
- Each pass takes 67 cycles, from start through the finish cycle inclusive.
- out_valid and digest stay stable until the cycle in which out_ready = 1.
- Best-case throughput is one header per 203 cycles (miss) or 136 cycles (hit).

## Configuration
- `SHA256D_MIDSTATE_CACHE_EN` defined:
  - Add a 512-bit tag register, a 256-bit cached midstate and a valid bit.
  - A hit is valid && tag == header[639:128]; C0 is skipped and the cached midstate is used.
  - On each C0 finish, write the tag and midstate and set valid.
  - Reset clears valid.
- Undefined: C0 always runs, no tag storage is built, and latency is always T+202.

## Structure
- Package `sha256_pkg`:
  - SHA256_IV as 256 bits: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - Padding word 32'h80000000.
  - Length constants 640 and 256.
- The FSM enum is local to this module.
- The one sub-module is `sha256_compress`, instantiated once inside this block. No other hierarchy.

## Test plan
- Genesis header 0100…0000 3ba3edfd…4b1e5e4a 29ab5f49 ffff001d 1dac2b7c, accepted at T:
  - out_valid at T+202.
  - digest = 6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000.
- Same header again with nonce changed to 1dac2b7d: digest matches the software model. With the cache macro, out_valid at T+135; without it, T+202.
- out_ready held low for 20 cycles after out_valid: digest stays stable, in_ready = 0 and busy = 1 throughout, then IDLE one cycle after out_ready.
- in_valid pulsed with a different header at T+50: ignored, and the first header's digest is returned unchanged.
- reset asserted at T+100:
  - out_valid = 0, in_ready = 1 and busy = 0 on the next cycle.
  - No core finish is acted on.
  - Resubmitting the genesis header takes the full T+202 even with the cache enabled, because the cache was invalidated.
- 100 random headers back-to-back with out_ready tied high: all digests match the model, and accept-to-accept spacing is exactly 203 cycles without cache hits.
